conv_row_ctrl: RTL and testbench

CONV_ROW_CTRL -- requirements
Module: conv_row_ctrl

---
 rtl/conv_row_ctrl.sv | 257 +++++++++++++++++++++++++
 tb/tb_conv_row_ctrl.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_row_ctrl.sv
// conv_row_ctrl: sequences one row job of a chained-PE 1-D convolution.
// Latency: an issued window's PE sum is buffered 2 cycles after issue; it appears on o_out_data the cycle after.
// Backpressure: input accepted only while FIFO entries + in-flight sums leave room; o_out_valid held until i_out_ready.
// Build option: define CONV_ROW_CTRL_RELU_EN to clamp negative sums to zero before they are buffered.
// TAPS must be >= 2 (weight address width is clog2(TAPS)); FIFO_DEPTH must be a power of two >= 2.
module conv_row_ctrl #(
  parameter int TAPS       = 3,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_start,
  input  logic [7:0]                i_len,
  output logic                      o_busy,
  output logic                      o_done,
  input  logic                      i_wgt_we,
  input  logic [$clog2(TAPS)-1:0]   i_wgt_addr,
  input  logic [7:0]                i_wgt_data,
  input  logic                      i_in_valid,
  output logic                      o_in_ready,
  input  logic [7:0]                i_in_data,
  output logic [8*TAPS-1:0]         o_pe_ifmap,
  output logic [8*TAPS-1:0]         o_pe_filter,
  input  logic [19:0]               i_pe_psum,
  output logic                      o_out_valid,
  input  logic                      i_out_ready,
  output logic [19:0]               o_out_data
);

  localparam int AW = $clog2(TAPS);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FILL  = 3'd1,
    S_RUN   = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  // FSM state
  state_t          r_state;
  state_t          w_state_nxt;

  // Job bookkeeping
  logic [7:0]      r_len;
  logic [7:0]      r_issued;
  logic [7:0]      w_issued_nxt;
  logic [AW-1:0]   r_fill_cnt;

  // Sample window and weights; index 0 holds the oldest sample
  logic [7:0]      r_win [TAPS];
  logic [7:0]      r_wgt [TAPS];

  // PE latency tracker: bit 0 = issued last cycle, bit 1 = sum valid now
  logic [1:0]      r_vpipe;
  logic [1:0]      w_inflight;

  // Result FIFO
  logic [19:0]     r_mem [FIFO_DEPTH];
  logic [PW-1:0]   r_wr_ptr;
  logic [PW-1:0]   r_rd_ptr;
  logic [CW-1:0]   r_count;
  logic [CW:0]     w_credit;
  logic            w_credit_ok;
  logic            w_empty;
  logic            w_push;
  logic            w_pop;
  logic [19:0]     w_push_dat;

  // Handshake qualifiers
  logic            w_start_ok;
  logic            w_in_fire;
  logic            w_fill_fire;
  logic            w_fill_last;
  logic            w_issue;
  logic            w_last_issue;
  logic            w_room;

  assign w_start_ok   = (r_state == S_IDLE) && i_start;
  assign w_in_fire    = i_in_valid && o_in_ready;
  assign w_fill_fire  = (r_state == S_FILL) && w_in_fire;
  assign w_fill_last  = w_fill_fire && (r_fill_cnt == AW'(TAPS - 2));
  assign w_issue      = (r_state == S_RUN) && w_in_fire;
  assign w_issued_nxt = r_issued + 8'd1;
  assign w_last_issue = w_issue && (w_issued_nxt == r_len);

  assign w_inflight   = {1'b0, r_vpipe[0]} + {1'b0, r_vpipe[1]};
  // An issue is only allowed when its sum is guaranteed a FIFO slot,
  // counting sums still travelling through the PE chain.
  assign w_credit     = {1'b0, r_count} + (CW+1)'(w_inflight);
  assign w_credit_ok  = w_credit < (CW+1)'(FIFO_DEPTH);
  assign w_room       = (r_issued < r_len) && w_credit_ok;

  assign w_empty      = (r_count == '0);
  assign w_push       = r_vpipe[1];
  assign w_pop        = o_out_valid && i_out_ready;

`ifdef CONV_ROW_CTRL_RELU_EN
  assign w_push_dat   = i_pe_psum[19] ? 20'd0 : i_pe_psum;
`else
  assign w_push_dat   = i_pe_psum;
`endif

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_state_nxt = (i_len == 8'd0) ? S_DONE : S_FILL;
        end
      end
      S_FILL: begin
        if (w_fill_last) begin
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        if (w_last_issue) begin
          w_state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if ((w_inflight == 2'd0) && w_empty) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State-dependent outputs
  always_comb begin
    o_busy     = 1'b1;
    o_done     = 1'b0;
    o_in_ready = 1'b0;
    case (r_state)
      S_IDLE:  o_busy     = 1'b0;
      S_FILL:  o_in_ready = 1'b1;
      S_RUN:   o_in_ready = w_room;
      S_DONE:  o_done     = 1'b1;
      default: o_in_ready = 1'b0;
    endcase
  end

  // Job length capture, issue count and fill progress
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_len      <= 8'd0;
      r_issued   <= 8'd0;
      r_fill_cnt <= '0;
    end else if (w_start_ok) begin
      r_len      <= i_len;
      r_issued   <= 8'd0;
      r_fill_cnt <= '0;
    end else begin
      if (w_fill_fire) begin
        r_fill_cnt <= r_fill_cnt + AW'(1);
      end
      if (w_issue) begin
        r_issued <= w_issued_nxt;
      end
    end
  end

  // Window shift: accepted samples enter at the newest tap, oldest falls out of tap 0
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < TAPS; i++) begin
        r_win[i] <= 8'd0;
      end
    end else if (w_fill_fire || w_issue) begin
      for (int i = 0; i < TAPS - 1; i++) begin
        r_win[i] <= r_win[i+1];
      end
      r_win[TAPS-1] <= i_in_data;
    end
  end

  // Weight registers, writable only while idle so a running job sees a stable filter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < TAPS; i++) begin
        r_wgt[i] <= 8'd0;
      end
    end else if ((r_state == S_IDLE) && i_wgt_we) begin
      for (int i = 0; i < TAPS; i++) begin
        if (i_wgt_addr == AW'(i)) begin
          r_wgt[i] <= i_wgt_data;
        end
      end
    end
  end

  // PE latency pipe; a reset drops any sums still in the chain
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vpipe <= 2'b00;
    end else begin
      r_vpipe <= {r_vpipe[0], w_issue};
    end
  end

  // FIFO storage; contents are don't-care while empty since the output is gated
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= w_push_dat;
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_out_valid = !w_empty;
  assign o_out_data  = w_empty ? 20'd0 : r_mem[r_rd_ptr];

  // Flatten window and weights onto the PE buses, tap i at bits [8i+7:8i]
  for (genvar gi = 0; gi < TAPS; gi++) begin : g_pe_bus
    assign o_pe_ifmap[8*gi +: 8]  = r_win[gi];
    assign o_pe_filter[8*gi +: 8] = r_wgt[gi];
  end

endmodule

// File: tb/tb_conv_row_ctrl.sv
// tb_conv_row_ctrl: directed and randomized row jobs against a dot-product reference.
// The PE chain is modelled as one register stage after the driven window.
`timescale 1ns/1ps
module tb_conv_row_ctrl;

  localparam int TAPS       = 3;
  localparam int FIFO_DEPTH = 4;
  localparam int AW         = $clog2(TAPS);

  logic                clk = 1'b0;
  logic                rst;
  logic                i_start;
  logic [7:0]          i_len;
  logic                o_busy;
  logic                o_done;
  logic                i_wgt_we;
  logic [AW-1:0]       i_wgt_addr;
  logic [7:0]          i_wgt_data;
  logic                i_in_valid;
  logic                o_in_ready;
  logic [7:0]          i_in_data;
  logic [8*TAPS-1:0]   o_pe_ifmap;
  logic [8*TAPS-1:0]   o_pe_filter;
  logic [19:0]         pe_psum_r;
  logic                o_out_valid;
  logic                i_out_ready;
  logic [19:0]         o_out_data;

  int          n_total = 0;
  int          n_bad   = 0;
  int          wm [TAPS];
  int          samp [$];
  logic [19:0] expq [$];

  conv_row_ctrl #(.TAPS(TAPS), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .i_start     (i_start),
    .i_len       (i_len),
    .o_busy      (o_busy),
    .o_done      (o_done),
    .i_wgt_we    (i_wgt_we),
    .i_wgt_addr  (i_wgt_addr),
    .i_wgt_data  (i_wgt_data),
    .i_in_valid  (i_in_valid),
    .o_in_ready  (o_in_ready),
    .i_in_data   (i_in_data),
    .o_pe_ifmap  (o_pe_ifmap),
    .o_pe_filter (o_pe_filter),
    .i_pe_psum   (pe_psum_r),
    .o_out_valid (o_out_valid),
    .i_out_ready (i_out_ready),
    .o_out_data  (o_out_data)
  );

  always #5 clk = ~clk;

  function automatic logic [19:0] dot(input logic [8*TAPS-1:0] a, input logic [8*TAPS-1:0] b);
    int acc;
    acc = 0;
    for (int i = 0; i < TAPS; i++) begin
      acc = acc + int'($signed(a[8*i +: 8])) * int'($signed(b[8*i +: 8]));
    end
    return 20'(acc);
  endfunction

  // PE chain stand-in: sum of the presented window, one register stage later
  always @(posedge clk) pe_psum_r <= dot(o_pe_ifmap, o_pe_filter);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [8*TAPS-1:0] pack_w();
    logic [8*TAPS-1:0] v;
    v = '0;
    for (int i = 0; i < TAPS; i++) v[8*i +: 8] = 8'(wm[i]);
    return v;
  endfunction

  task automatic set_w(input int idx, input int val);
    i_wgt_we   = 1'b1;
    i_wgt_addr = AW'(idx);
    i_wgt_data = 8'(val);
    @(posedge clk); #1;
    i_wgt_we   = 1'b0;
    wm[idx]    = val;
  endtask

  task automatic rand_samples(input int n);
    samp.delete();
    for (int k = 0; k < n + TAPS - 1; k++) samp.push_back(int'($urandom_range(255)) - 128);
  endtask

  // Expected result k is the dot product of weights with samples k..k+TAPS-1
  task automatic build_exp(input int n);
    expq.delete();
    for (int k = 0; k < n; k++) begin
      int acc = 0;
      for (int i = 0; i < TAPS; i++) acc += wm[i] * samp[k+i];
`ifdef CONV_ROW_CTRL_RELU_EN
      if (acc < 0) acc = 0;
`endif
      expq.push_back(20'(acc));
    end
  endtask

  // Runs one job from IDLE. hold: cycles with out_ready forced low; disturb: start+weight write mid-job;
  // abort_at: return early once that many results were taken (caller then resets).
  task automatic run_job(input int n, input int in_pct, input int out_pct, input int hold,
                         input bit disturb, input int abort_at);
    int  cyc = 0, sent = 0, got = 0, dn = 0;
    int  nsamp;
    bit  in_fire;
    nsamp = (n > 0) ? n + TAPS - 1 : 0;
    while (dn == 0 && cyc < 3000) begin
      i_start     = (cyc == 0) || (disturb && cyc == 5);
      i_len       = (cyc == 0) ? 8'(n) : 8'd1;
      i_wgt_we    = disturb && (cyc == 5);
      i_wgt_addr  = '0;
      i_wgt_data  = 8'h55;
      i_in_valid  = (sent < nsamp) && ($urandom_range(99) < in_pct);
      i_in_data   = (sent < nsamp) ? 8'(samp[sent]) : 8'h00;
      i_out_ready = (cyc >= hold) && ($urandom_range(99) < out_pct);
      @(negedge clk);
      in_fire = i_in_valid && o_in_ready;
      if (o_out_valid && i_out_ready) begin
        if (got < expq.size()) check("out_data", 32'(o_out_data), 32'(expq[got]));
        got++;
      end
      if (o_done) dn++;
      if (hold > 0 && cyc == hold - 1) begin
        check("bp_accepted", 32'(sent), 32'(TAPS - 1 + FIFO_DEPTH));
        check("bp_in_ready", 32'(o_in_ready), 32'd0);
        check("bp_out_valid", 32'(o_out_valid), 32'd1);
      end
      @(posedge clk); #1;
      if (in_fire) sent++;
      cyc++;
      if (abort_at > 0 && got == abort_at) break;
    end
    i_start = 1'b0; i_in_valid = 1'b0; i_out_ready = 1'b0; i_wgt_we = 1'b0;
    if (abort_at == 0) begin
      check("done_seen", 32'(dn), 32'd1);
      check("result_count", 32'(got), 32'(n));
      check("samples_taken", 32'(sent), 32'(nsamp));
      @(negedge clk);
      check("busy_after", 32'(o_busy), 32'd0);
      check("done_width", 32'(o_done), 32'd0);
      @(posedge clk); #1;
    end else begin
      check("abort_reached", 32'(got), 32'(abort_at));
    end
  endtask

  initial begin
    rst = 1'b1; i_start = 1'b0; i_len = 8'd0; i_wgt_we = 1'b0; i_wgt_addr = '0;
    i_wgt_data = 8'd0; i_in_valid = 1'b0; i_in_data = 8'd0; i_out_ready = 1'b0;
    for (int i = 0; i < TAPS; i++) wm[i] = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", 32'(o_busy), 32'd0);
    check("rst_done", 32'(o_done), 32'd0);
    check("rst_in_ready", 32'(o_in_ready), 32'd0);
    check("rst_out_valid", 32'(o_out_valid), 32'd0);
    check("rst_ifmap", 32'(o_pe_ifmap), 32'd0);
    check("rst_filter", 32'(o_pe_filter), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Basic run: weights 1,2,3 over samples 1..5
    set_w(0, 1); set_w(1, 2); set_w(2, 3);
    @(negedge clk);
    check("pe_filter_load", 32'(o_pe_filter), 32'(pack_w()));
    @(posedge clk); #1;
    samp = {1, 2, 3, 4, 5};
    expq = {20'd14, 20'd20, 20'd26};
    run_job(3, 100, 100, 0, 1'b0, 0);

    // Signed extremes
    set_w(0, -128); set_w(1, -128); set_w(2, -128);
    samp = {-128, -128, -128, -128};
    expq = {20'h0C000, 20'h0C000};
    run_job(2, 100, 100, 0, 1'b0, 0);
    set_w(0, 127); set_w(1, 127); set_w(2, 127);
`ifdef CONV_ROW_CTRL_RELU_EN
    expq = {20'h00000, 20'h00000};
`else
    expq = {20'hF4180, 20'hF4180};
`endif
    run_job(2, 100, 100, 0, 1'b0, 0);

    // Backpressure: out_ready low long enough for the credit limit to stall input
    set_w(0, 1); set_w(1, 2); set_w(2, 3);
    rand_samples(8); build_exp(8);
    run_job(8, 100, 100, 30, 1'b0, 0);

    // len == 0: done one cycle after start, input never requested
    i_start = 1'b1; i_len = 8'd0;
    @(negedge clk);
    check("len0_in_ready_c0", 32'(o_in_ready), 32'd0);
    check("len0_done_c0", 32'(o_done), 32'd0);
    @(posedge clk); #1;
    i_start = 1'b0;
    @(negedge clk);
    check("len0_done_c1", 32'(o_done), 32'd1);
    check("len0_in_ready_c1", 32'(o_in_ready), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check("len0_done_c2", 32'(o_done), 32'd0);
    check("len0_busy_c2", 32'(o_busy), 32'd0);
    @(posedge clk); #1;

    // Start and weight write while busy are ignored; next job keeps old weights
    set_w(0, -7); set_w(1, 45); set_w(2, -100);
    rand_samples(10); build_exp(10);
    run_job(10, 80, 80, 0, 1'b1, 0);
    check("wgt_hold", 32'(o_pe_filter), 32'(pack_w()));
    rand_samples(5); build_exp(5);
    run_job(5, 90, 90, 0, 1'b0, 0);

    // Randomized jobs
    for (int j = 0; j < 6; j++) begin
      for (int i = 0; i < TAPS; i++) set_w(i, int'($urandom_range(255)) - 128);
      begin
        int n;
        n = int'($urandom_range(1, 20));
        rand_samples(n); build_exp(n);
        run_job(n, int'($urandom_range(50, 100)), int'($urandom_range(30, 100)), 0, 1'b0, 0);
      end
    end

    // Reset in the middle of a run after two results
    set_w(0, 1); set_w(1, 2); set_w(2, 3);
    rand_samples(8); build_exp(8);
    run_job(8, 100, 100, 0, 1'b0, 2);
    rst = 1'b1;
    #1;
    check("mid_rst_busy", 32'(o_busy), 32'd0);
    check("mid_rst_done", 32'(o_done), 32'd0);
    check("mid_rst_in_ready", 32'(o_in_ready), 32'd0);
    check("mid_rst_out_valid", 32'(o_out_valid), 32'd0);
    check("mid_rst_out_data", 32'(o_out_data), 32'd0);
    check("mid_rst_ifmap", 32'(o_pe_ifmap), 32'd0);
    check("mid_rst_filter", 32'(o_pe_filter), 32'd0);
    for (int i = 0; i < TAPS; i++) wm[i] = 0;
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("post_rst_out_valid", 32'(o_out_valid), 32'd0);
      @(posedge clk); #1;
    end
    set_w(0, 1); set_w(1, 2); set_w(2, 3);
    samp = {1, 2, 3, 4, 5};
    expq = {20'd14, 20'd20, 20'd26};
    run_job(3, 100, 100, 0, 1'b0, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
